// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32I funct3 encodings, ram write-enable codes
// and the request legality/alignment helpers used by the lsu front end.
package lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [2:0] MEM_WE_WORD = 3'b001;
    localparam logic [2:0] MEM_WE_HALF = 3'b010;
    localparam logic [2:0] MEM_WE_BYTE = 3'b100;

    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        else
            return funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    endfunction

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic [2:0] size_we(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return MEM_WE_BYTE;
            2'b01:   return MEM_WE_HALF;
            default: return MEM_WE_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic write, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo, input logic io_region);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        if (write && io_region && (funct3[1:0] != 2'b00))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: selects byte/half/word from the ram's pre-shifted
// read data and applies sign or zero extension according to funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (funct3)
            FUNCT3_LB:  result = {{24{data[7]}}, data[7:0]};
            FUNCT3_LH:  result = {{16{data[15]}}, data[15:0]};
            FUNCT3_LBU: result = {24'b0, data[7:0]};
            FUNCT3_LHU: result = {16'b0, data[15:0]};
            default:    result = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, checks legality, drives the ram for
// one cycle and returns an extended load result or store completion.
module lsu
    import lsu_pkg::*;
#(
    parameter int IO_BASE_BIT = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    state_t      state_reg;
    logic [2:0]  funct3_reg;
    logic        write_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_fault_reg;
    logic [2:0]  mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] extended;
    logic        req_bad;

    assign req_bad = !funct3_legal(req_write, req_funct3)
                   || misaligned(req_write, req_funct3, req_addr[1:0], req_addr[IO_BASE_BIT]);

    lsu_extend u_extend (
        .funct3 (funct3_reg),
        .data   (mem_rdata),
        .result (extended)
    );

    // ram read data only arrives during RESP, so the load result is steered
    // straight from mem_rdata rather than registered a second time
    assign rsp_rdata = (state_reg == RESP && !write_reg) ? extended : 32'b0;
    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_fault = rsp_fault_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            funct3_reg    <= 3'b0;
            write_reg     <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= 1'b0;
            mem_we_reg    <= 3'b0;
            mem_addr_reg  <= 32'b0;
            mem_wdata_reg <= 32'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg    <= req_funct3;
                        write_reg     <= req_write;
                        req_ready_reg <= 1'b0;
                        if (req_bad) begin
                            state_reg     <= FAULT;
                            rsp_valid_reg <= 1'b1;
                            rsp_fault_reg <= 1'b1;
                        end else begin
                            // the ram bus only moves for legal requests
                            state_reg     <= ACCESS;
                            mem_addr_reg  <= req_addr;
                            mem_wdata_reg <= req_wdata;
                            mem_we_reg    <= req_write ? size_we(req_funct3) : 3'b000;
                        end
                    end
                end
                ACCESS: begin
                    state_reg     <= RESP;
                    mem_we_reg    <= 3'b000;
                    rsp_valid_reg <= 1'b1;
                end
                RESP, FAULT: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    rsp_fault_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, reset/back-to-back sequences
// and randomized requests against a byte-addressed memory reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [2:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu #(.IO_BASE_BIT(29)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Environment: 256-byte ram (not reset) with registered, pre-shifted read, plus gpio byte
    logic [7:0]  ram [256];
    logic [7:0]  gpio = 8'h00;
    logic [31:0] ram_q = 32'b0;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        int n;
        n = (mem_we == 3'b001) ? 4 : (mem_we == 3'b010) ? 2 : (mem_we == 3'b100) ? 1 : 0;
        if (n != 0) begin
            if (mem_addr[29]) gpio <= mem_wdata[7:0];
            else for (int k = 0; k < n; k++) ram[8'(int'(mem_addr[7:0]) + k)] <= mem_wdata[8*k +: 8];
        end
        ram_q <= {ram[{mem_addr[7:2], 2'b11}], ram[{mem_addr[7:2], 2'b10}],
                  ram[{mem_addr[7:2], 2'b01}], ram[{mem_addr[7:2], 2'b00}]} >> (8 * mem_addr[1:0]);
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    logic [7:0] ref_gpio = 8'h00;

    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt, output int lat, output logic [2:0] we);
        int sz;
        logic legal;
        longint v;
        longint one = 1;
        sz = 1 << (f3 & 3);
        legal = w ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        rd = 0; we = 0;
        if (!legal || (a % sz) != 0 || (w && a[29] && sz != 1)) begin
            flt = 1; lat = 1;
        end else begin
            flt = 0; lat = 2;
            if (w) begin
                we = (sz == 4) ? 3'b001 : (sz == 2) ? 3'b010 : 3'b100;
                if (a[29]) ref_gpio = d[7:0];
                else for (int k = 0; k < sz; k++) ref_mem[8'(int'(a[7:0]) + k)] = d[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < sz; k++) v += longint'(ref_mem[8'(int'(a[7:0]) + k)]) << (8 * k);
                if (f3 < 4 && sz < 4 && v >= (one << (8 * sz - 1))) v -= (one << (8 * sz));
                rd = v[31:0];
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic flt, output int lat,
                           output logic [2:0] we_or, output int we_cycles);
        int waitc = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 10) check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        rd = 0; flt = 0; lat = 0; we_or = 0; we_cycles = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 0;
            if (mem_we != 0) begin
                we_or |= mem_we;
                we_cycles++;
            end
            if (rsp_valid && lat == 0) begin
                lat = i; rd = rsp_rdata; flt = rsp_fault;
            end
        end
        $display("req w=%0d f3=%0d addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d we=%b",
                 w, f3, a, d, rd, flt, lat, we_or);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        logic [2:0]  exp_we;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ef, input int el, input logic [2:0] ew);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el; v.exp_we = ew;
        return v;
    endfunction

    task automatic check_rsp(input string tag, input logic [31:0] rd, input logic flt, input int lat,
                             input logic [2:0] we_or, input int we_cycles,
                             input logic [31:0] er, input logic ef, input int el, input logic [2:0] ew);
        check({tag, "_rdata"}, rd, er);
        check({tag, "_fault"}, 32'(flt), 32'(ef));
        check({tag, "_latency"}, 32'(lat), 32'(el));
        check({tag, "_mem_we"}, 32'(we_or), 32'(ew));
        check({tag, "_we_cycles"}, 32'(we_cycles), (ew != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] rd, er;
        logic flt, ef;
        int lat, el, we_cycles;
        logic [2:0] we_or, ew;
        int rsp_cyc[$];
        logic [31:0] rsp_dat[$];
        int c0;
        logic seen;

        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);

        // Directed table
        tbl.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 3'b001));
        tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 3'b000));
        tbl.push_back(mk(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0, 2, 3'b001));
        tbl.push_back(mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2, 3'b000));
        tbl.push_back(mk(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 2, 3'b000));
        tbl.push_back(mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 0, 2, 3'b000));
        tbl.push_back(mk(0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 0, 2, 3'b000));
        tbl.push_back(mk(1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 0, 2, 3'b010));
        tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hABCD7F01, 0, 2, 3'b000));
        tbl.push_back(mk(0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 1, 3'b000));
        tbl.push_back(mk(1, 3'b001, 32'h13, 32'h1234, 32'h0, 1, 1, 3'b000));
        tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hABCD7F01, 0, 2, 3'b000));
        tbl.push_back(mk(1, 3'b000, 32'h20000000, 32'h0000005A, 32'h0, 0, 2, 3'b100));
        tbl.push_back(mk(1, 3'b010, 32'h20000000, 32'h11223344, 32'h0, 1, 1, 3'b000));
        tbl.push_back(mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 3'b000));
        tbl.push_back(mk(1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 1, 3'b000));
        tbl.push_back(mk(0, 3'b101, 32'h11, 32'h0, 32'h0, 1, 1, 3'b000));

        foreach (tbl[i]) begin
            model(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, er, ef, el, ew);
            run_req(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, flt, lat, we_or, we_cycles);
            check_rsp($sformatf("tbl%0d", i), rd, flt, lat, we_or, we_cycles,
                      tbl[i].exp_rdata, tbl[i].exp_fault, tbl[i].exp_lat, tbl[i].exp_we);
        end
        check("gpio_after_io_stores", 32'(gpio), 32'h5A);

        // Reset while an LW sits in ACCESS: no response, ready right after reset
        @(negedge clk);
        req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rst_access_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_access_req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("rst_access_no_late_rsp", 32'(seen), 32'd0);

        // Back-to-back LW held on req_valid: responses 3 cycles apart
        model(0, 3'b010, 32'h10, 32'h0, er, ef, el, ew);
        @(negedge clk);
        req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        c0 = cyc;
        repeat (11) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back(rsp_rdata);
            end
        end
        req_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back(rsp_rdata);
            end
        end
        $display("back-to-back: %0d responses", rsp_cyc.size());
        check("b2b_count_ge3", 32'(rsp_cyc.size() >= 3), 32'd1);
        if (rsp_cyc.size() >= 3) begin
            check("b2b_first_latency", 32'(rsp_cyc[0] - c0), 32'd2);
            for (int i = 1; i < 3; i++) begin
                check($sformatf("b2b_gap%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
                check($sformatf("b2b_rdata%0d", i), rsp_dat[i], er);
            end
        end

        // Randomized requests against the reference model
        for (int i = 0; i < 300; i++) begin
            logic w;
            logic [2:0] f3;
            logic [31:0] a, d;
            w = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a[29] = 1'b1;
            d = $urandom;
            model(w, f3, a, d, er, ef, el, ew);
            run_req(w, f3, a, d, rd, flt, lat, we_or, we_cycles);
            check_rsp($sformatf("rnd%0d", i), rd, flt, lat, we_or, we_cycles, er, ef, el, ew);
        end
        check("gpio_final", 32'(gpio), 32'(ref_gpio));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
